cpu_out_serializer: RTL and testbench
=====================================

# cpu_out_serializer

Multi-channel output serializer between the pipelined RISC-V CPU core and the 8-bit TinyTapeout output pins. Accepts wide result/debug words from `NUM_CH` CPU-side channels through valid/ready handshakes, buffers them in a shared FIFO, and streams them out as framed byte sequences: one header byte, then the data bytes LSB-first. It replaces the fixed 16-bit direct pin mapping with a width- and channel-agnostic, back-pressured byte stream.

## Interface
Parameters:
- `DATA_W`, 16: channel word width; must be a multiple of 8, range 8..64.
- `NUM_CH`, 2: number of input channels, range 1..16.
- `FIFO_DEPTH`, 4: shared FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock for the block.
- `rst`  in  1  asynchronous, active-high reset. The top level drives it from the inverted pin reset.
- `in_valid`  in  NUM_CH  per-channel word valid.
- `in_data`  in  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- `in_ready`  out  NUM_CH  per-channel accept; at most one bit is high per cycle.
- `out_data`  out  8  current byte (registered).
- `out_valid`  out  1  `out_data` is valid (registered).
- `out_ready`  in  1  host accepts the byte.
- `out_sof`  out  1  high while `out_data` is a header byte.

## Operation
- Input arbitration:
  - Round-robin pointer `rr` (reset 0). Search starts at `rr`.
  - `in_ready[g]` = 1 for the first channel g with `in_valid[g]`, only when FIFO count < FIFO_DEPTH and `rst` is low. Combinational from `in_valid` and registered count.
  - On a transfer (`in_valid[g] & in_ready[g]`), push {g, word} and set `rr` = (g+1) mod NUM_CH.
  - No valid inputs → `rr` unchanged.
- FIFO: registered write; no fall-through. A pop frees space for the next cycle only, so a push is refused when full even if a pop occurs in the same cycle. Push and pop in the same cycle are allowed when not full.
- Serializer FSM: IDLE → HDR → DATA → (TRL) → HDR or IDLE.
  - IDLE: if FIFO is non-empty, pop on the next edge, present header 8'hA0 | ch, set `out_sof`=1, go to HDR.
  - HDR: on `out_valid & out_ready`, present byte 0 and go to DATA.
  - DATA: byte counter 0..DATA_W/8-1. Each accepted byte advances to the next byte. On the last byte:
    - SER_PARITY_EN defined → go to TRL.
    - Otherwise → the frame ends.
  - Frame end: if the FIFO is non-empty, pop and present the next header on the same edge (no idle cycle). Otherwise clear `out_valid` and go to IDLE.
- `out_data` and `out_valid` are held stable while `out_valid & ~out_ready`.
- Reset (any time, including mid-frame): FIFO is emptied, FSM goes to IDLE, `rr`=0, `out_valid`=0, `out_data`=0, `out_sof`=0, `in_ready`=0. The partial frame is discarded.

## Timing
- Word accepted at edge k. Header presented (`out_valid`=1) after edge k+1 when the FSM is idle.
- Frame length is 1+DATA_W/8 bytes, plus 1 with parity. Throughput is one byte per cycle when `out_ready` stays high.
- FIFO full is visible to `in_ready` in the cycle after the filling push.

## Configuration
- `SER_PARITY_EN`:
  - Defined: after the last data byte, emit a trailer byte equal to the XOR of all data bytes of the frame (header excluded). State TRL is present.
  - Undefined: no trailer, TRL and the XOR register are absent, and frames are 1+DATA_W/8 bytes.

## Structure
- Package `cpu_io_pkg`:
  - `HDR_TAG` = 4'hA.
  - FSM state enum {IDLE, HDR, DATA, TRL}.
  - Function `clog2_min1(n)` for the widths of the pointer, channel-id and byte counter.
- Sub-module `sync_fifo` (params WIDTH, DEPTH): registered read, count output, async active-high reset. Instantiated with WIDTH = 4 + DATA_W.
- Arbiter and FSM live in `cpu_out_serializer`.

## Test plan
All cases use DATA_W=16, NUM_CH=2, FIFO_DEPTH=4 unless stated.
- Single word: ch1 sends 16'hBEEF with `out_ready`=1 → bytes A1 (sof=1), EF, BE. `out_valid` rises 2 edges after acceptance, then drops.
- Round-robin: both channels are valid continuously from reset → grants alternate ch0, ch1, ch0…; the `in_ready` bits are never high together.
- Back-pressure: `out_ready`=0 for 5 cycles mid-frame → `out_data` and `out_valid` are stable; no byte is lost or duplicated.
- FIFO full: `out_ready`=0 and 5 words offered → 4 accepted (1 already loaded), further `in_ready`=0; push refused during a simultaneous pop at full.
- Reset mid-frame: assert `rst` during byte 1 → all outputs 0 immediately. After release, the next word gives a clean header.
- SER_PARITY_EN: ch0 sends 16'h1234 → bytes A0, 34, 12, 26.

Source files
------------

// File: rtl/cpu_io_pkg.sv
// cpu_io_pkg: shared header tag, serializer states and width helper for the CPU output path.
package cpu_io_pkg;
  localparam logic [3:0] HDR_TAG = 4'hA;
  typedef enum logic [1:0] {IDLE, HDR, DATA, TRL} ser_state_e;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: registered-read FIFO with occupancy count; head exposes the next entry for lookahead.
module sync_fifo import cpu_io_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             dout,
  output logic [WIDTH-1:0]             head,
  output logic [clog2_min1(DEPTH):0]   count
);
  localparam int AW = clog2_min1(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign wr = push && count != FULL;
  assign rd = pop && count != '0;
  assign head = mem[rp];
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      dout <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) begin
        rp <= rp + 1'b1;
        dout <= mem[rp];
      end
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
endmodule

// File: rtl/cpu_out_serializer.sv
// cpu_out_serializer: round-robin channel arbiter + shared FIFO + framed byte serializer (header, data LSB-first).
// Optional parity trailer byte enabled by defining SER_PARITY_EN.
module cpu_out_serializer import cpu_io_pkg::*; #(
  parameter int DATA_W     = 16,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sof
);
  localparam int NB = DATA_W / 8;
  localparam int BW = clog2_min1(NB);
  localparam int CW = clog2_min1(NUM_CH);
  localparam int AW = clog2_min1(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  logic [AW:0] count;
  logic [DATA_W+3:0] din, dout, head;
  logic [DATA_W-1:0] word;
  logic [CW-1:0] rr, gnt;
  logic found, push, pop, fire, last, frame_end, start;
  ser_state_e state, state_n;
  logic [BW-1:0] cnt, cnt_n, nb;
  logic [7:0] data_n;
  logic valid_n, sof_n;
  logic unused_bits;
  always_comb begin
    found = 1'b0;
    gnt = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (!found && in_valid[(int'(rr) + k) % NUM_CH]) begin
        found = 1'b1;
        gnt = CW'((int'(rr) + k) % NUM_CH);
      end
  end
  assign in_ready = (found && count < FULL && !rst) ? NUM_CH'(1) << gnt : '0;
  assign push = |in_ready;
  assign din = {4'(gnt), in_data[gnt*DATA_W +: DATA_W]};
  always_ff @(posedge clk or posedge rst)
    if (rst) rr <= '0;
    else if (push) rr <= (gnt == CW'(NUM_CH-1)) ? '0 : gnt + 1'b1;
  sync_fifo #(.WIDTH(DATA_W + 4), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .din(din), .pop(pop),
    .dout(dout), .head(head), .count(count)
  );
  assign word = dout[DATA_W-1:0];
  assign unused_bits = ^{head[DATA_W-1:0], dout[DATA_W+3:DATA_W]};
  assign fire = out_valid && out_ready;
  assign last = cnt == BW'(NB-1);
  assign nb = cnt + 1'b1;
`ifdef SER_PARITY_EN
  logic [7:0] par, par_n;
  assign frame_end = state == TRL && fire;
`else
  assign frame_end = state == DATA && fire && last;
`endif
  // A finishing frame may immediately start the next one, giving back-to-back frames.
  assign start = (state == IDLE || frame_end) && count != '0;
  assign pop = start;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    data_n = out_data;
    valid_n = out_valid;
    sof_n = out_sof;
`ifdef SER_PARITY_EN
    par_n = par;
`endif
    if (start) begin
      state_n = HDR;
      data_n = {HDR_TAG, head[DATA_W +: 4]};
      valid_n = 1'b1;
      sof_n = 1'b1;
    end else if (frame_end) begin
      state_n = IDLE;
      valid_n = 1'b0;
    end else if (fire && state == HDR) begin
      state_n = DATA;
      cnt_n = '0;
      data_n = word[7:0];
      sof_n = 1'b0;
`ifdef SER_PARITY_EN
      par_n = word[7:0];
`endif
    end else if (fire && state == DATA) begin
`ifdef SER_PARITY_EN
      if (last) begin
        state_n = TRL;
        data_n = par;
      end else begin
        cnt_n = nb;
        data_n = 8'(word >> {nb, 3'b0});
        par_n = par ^ data_n;
      end
`else
      cnt_n = nb;
      data_n = 8'(word >> {nb, 3'b0});
`endif
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      out_sof <= 1'b0;
`ifdef SER_PARITY_EN
      par <= '0;
`endif
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      out_data <= data_n;
      out_valid <= valid_n;
      out_sof <= sof_n;
`ifdef SER_PARITY_EN
      par <= par_n;
`endif
    end
endmodule

// File: tb/tb_cpu_out_serializer.sv
// tb_cpu_out_serializer: directed + random stimulus checked against a queue-level frame model.
module tb_cpu_out_serializer;
  localparam int DW = 16;
  localparam int NCH = 2;
  localparam int DEPTH = 4;
  localparam int NB = DW / 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NCH-1:0] in_valid = '0;
  logic [NCH*DW-1:0] in_data = '0;
  logic [NCH-1:0] in_ready;
  logic [7:0] out_data;
  logic out_valid, out_ready = 1'b0, out_sof;
  int passed = 0, total = 0;
  logic [DW+3:0] mq[$];
  logic [8:0] cur[$];
  logic [7:0] seen[$];
  int rr = 0;

  cpu_out_serializer #(.DATA_W(DW), .NUM_CH(NCH), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    cur.delete();
    rr = 0;
  endtask

  // Inputs are set at the falling edge; check just after, then advance the model at the rising edge.
  task automatic tick();
    int g;
    logic [NCH-1:0] er;
    logic [DW+3:0] w;
    logic [7:0] b, p;
    #1;
    g = -1;
    for (int k = 0; k < NCH; k++)
      if (g < 0 && in_valid[(rr + k) % NCH]) g = (rr + k) % NCH;
    er = (g >= 0 && mq.size() < DEPTH) ? NCH'(1) << g : '0;
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("ready_onehot", 32'($onehot0(in_ready)), 32'd1);
    chk("out_valid", 32'(out_valid), 32'(cur.size() != 0));
    chk("out_sof", 32'(out_sof), 32'(cur.size() != 0 && cur[0][8]));
    if (cur.size() != 0) chk("out_data", 32'(out_data), 32'(cur[0][7:0]));
    @(posedge clk);
    if (cur.size() != 0 && out_ready) begin
      seen.push_back(cur[0][7:0]);
      void'(cur.pop_front());
    end
    if (cur.size() == 0 && mq.size() != 0) begin
      w = mq.pop_front();
      cur.push_back({1'b1, 4'hA, w[DW +: 4]});
      p = 8'h00;
      for (int i = 0; i < NB; i++) begin
        b = w[i*8 +: 8];
        p ^= b;
        cur.push_back({1'b0, b});
      end
`ifdef SER_PARITY_EN
      cur.push_back({1'b0, p});
`endif
    end
    if (er != '0) begin
      mq.push_back({4'(g), in_data[g*DW +: DW]});
      rr = (g + 1) % NCH;
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    in_valid = '1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_sof", 32'(out_sof), 32'd0);
    in_valid = '0;
    rst = 1'b0;
    @(negedge clk);
    // single word on ch1
    seen.delete();
    out_ready = 1'b1;
    in_valid = 2'b10;
    in_data = {16'hBEEF, 16'h0000};
    tick();
    in_valid = '0;
    repeat (6) tick();
    chk("beef_hdr", 32'(seen[0]), 32'hA1);
    chk("beef_b0", 32'(seen[1]), 32'hEF);
    chk("beef_b1", 32'(seen[2]), 32'hBE);
`ifdef SER_PARITY_EN
    chk("beef_len", 32'(seen.size()), 32'd4);
    chk("beef_par", 32'(seen[3]), 32'h51);
`else
    chk("beef_len", 32'(seen.size()), 32'd3);
`endif
    // both channels valid: round-robin
    in_valid = 2'b11;
    in_data = {16'h5678, 16'h1234};
    repeat (12) tick();
    in_valid = '0;
    repeat (12) tick();
    // back-pressure mid-frame
    in_valid = 2'b01;
    in_data = {16'h0000, 16'hC3A5};
    tick();
    in_valid = '0;
    repeat (3) tick();
    out_ready = 1'b0;
    repeat (5) tick();
    out_ready = 1'b1;
    repeat (6) tick();
    // fill the FIFO while stalled, then pop at full
    out_ready = 1'b0;
    in_valid = 2'b01;
    for (int i = 0; i < 7; i++) begin
      in_data[15:0] = 16'(16'h1000 + i);
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = '0;
    repeat (20) tick();
    // reset mid-frame
    in_valid = 2'b10;
    in_data = {16'hDEAD, 16'h0000};
    tick();
    in_valid = '0;
    repeat (2) tick();
    in_valid = 2'b11;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_sof", 32'(out_sof), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    model_reset();
    in_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 2'b01;
    in_data = {16'h0000, 16'h1234};
    tick();
    in_valid = '0;
    repeat (6) tick();
    // random traffic
    repeat (400) begin
      in_valid = NCH'($urandom);
      in_data = {16'($urandom), 16'($urandom)};
      out_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    in_valid = '0;
    out_ready = 1'b1;
    repeat (30) tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
